dct_rle_encoder: RTL
====================

// Module: dct_rle_encoder
// PURPOSE
//  Downstream neighbour of the DCT/quantise/zigzag stage (dct_test1). Takes one packed block of
//  NCOEF zigzag-ordered quantised coefficients, as produced on that stage's C output, and emits a
//  stream of (run, level) tokens terminated by an end-of-block token. Its output feeds the
//  compressed-file writer or channel. Trailing zeros are never transmitted.
// PARAMETERS
//  COEF_W  64  width of one signed coefficient (matches C[l*64 +:64] slicing)
//  NCOEF   32  retained coefficients per 8x8 block (length of the ss pattern)
//  RUN_W   6   zero-run field width; must satisfy 2**RUN_W > NCOEF-1
//  CNT_W   16  width of the completed-block counter
// PORTS
//  clk        in   1              single clock, rising edge
//  rst        in   1              asynchronous, active-high reset
//  in_valid   in   1              in_coefs holds a block
//  in_ready   out  1              block accepted on an edge where in_valid && in_ready
//  in_coefs   in   NCOEF*COEF_W   coefficient i at [i*COEF_W +: COEF_W], two's complement
//  out_valid  out  1              token present on out_*
//  out_ready  in   1              sink takes token on an edge where out_valid && out_ready
//  out_run    out  RUN_W          zeros skipped before this level
//  out_level  out  COEF_W         signed nonzero coefficient; 0 for EOB
//  out_eob    out  1              token is end-of-block
//  blk_count  out  CNT_W          blocks whose EOB has been accepted, wraps at 2**CNT_W
// BEHAVIOUR
//  - Reset (async): state=IDLE, in_ready=1, out_valid=0, out_run=0, out_level=0, out_eob=0,
//    blk_count=0, idx=0, run_cnt=0. Reset mid-block discards the partial block and any pending token.
//  - FSM IDLE -> SCAN -> EOB -> IDLE. in_ready=1 only in IDLE.
//  - IDLE: on accept, latch in_coefs into buf, idx<=0, run_cnt<=0, go to SCAN.
//  - Stall = out_valid && !out_ready. While stalled, nothing advances and out_* holds stable.
//  - SCAN, each edge not stalled: examine buf[idx].
//      If nonzero: load out_run<=run_cnt, out_level<=buf[idx], out_eob<=0, out_valid<=1, run_cnt<=0.
//      If zero: run_cnt++. If the old token was accepted on the same edge, out_valid<=0.
//      idx++. After idx==NCOEF-1 is examined, go to EOB.
//  - EOB, not stalled: load out_run<=0, out_level<=0, out_eob<=1, out_valid<=1, then wait.
//    When the EOB token is accepted: out_valid<=0, out_eob<=0, blk_count++, go to IDLE.
//  - Accept and reload on the same edge keeps out_valid=1, so there are no bubbles.
//  - Throughput: NCOEF+1 edges per block plus stall cycles, plus 1 edge back to IDLE.
//  - Latency: first token visible after edge T+1 at the earliest, where T is the accept edge.
//  - run_cnt never exceeds NCOEF-1, so no overflow handling is needed.
//  - Comparisons and level are signed. out_level is bit-exact with the input slice; no truncation.
//  - in_coefs changes while not in IDLE have no effect. The block is buffered at accept.
// STRUCTURE
//  - Shared include dct_defs.vh: COEF_W, NCOEF, RUN_W, and the FSM state encodings
//    (ST_IDLE, ST_SCAN, ST_EOB), shared with the matching decoder.
//  - One natural sub-module: dct_coef_mux, a combinational NCOEF:1 selector buf -> buf[idx].
//  - Everything else is inline: FSM, idx and run counters, output token register, blk_count.
// TESTING
//  1. All-zero block, out_ready=1 -> exactly one token (run 0, level 0, eob 1); blk_count 0->1;
//     in_ready high again after the EOB is accepted.
//  2. c[0]=-5, c[3]=7, rest 0 -> tokens (0,-5), (2,7), EOB; no other tokens.
//  3. c[i]=i+1 for all i, out_ready=1 -> 32 tokens of run 0 with levels 1..32 on consecutive
//     cycles, then EOB; out_valid never drops; in_ready low throughout.
//  4. Only c[31]=1, out_ready random 50% -> (31,1) then EOB. Each token is held stable until
//     accepted; the sequence is identical to the out_ready=1 run.
//  5. Assert rst 3 tokens into case 3 -> all outputs zero immediately. Then feed case 2 ->
//     exact case-2 sequence; blk_count counts only completed blocks.
//  6. 3072 back-to-back random blocks with in_valid held high -> token stream matches the
//     reference-model RLE of out_dct.txt rows; blk_count=3072.

Source files
------------

// File: rtl/dct_rle_encoder_pkg.sv
// dct_rle_encoder_pkg: widths and FSM encoding shared by the RLE encoder and its matching decoder
package dct_rle_encoder_pkg;
  localparam int COEF_W = 64;
  localparam int NCOEF  = 32;
  localparam int RUN_W  = 6;
  localparam int CNT_W  = 16;
  localparam int IDX_W  = $clog2(NCOEF);
  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_EOB} state_t;
endpackage

// File: rtl/dct_rle_encoder_coef_mux.sv
// dct_coef_mux: combinational NCOEF:1 selector picking one coefficient out of the buffered block
module dct_coef_mux
  import dct_rle_encoder_pkg::*;
(
  input  logic [NCOEF*COEF_W-1:0] i_buf,
  input  logic [IDX_W-1:0]        i_idx,
  output logic [COEF_W-1:0]       o_coef
);
  assign o_coef = i_buf[i_idx*COEF_W +: COEF_W];
endmodule

// File: rtl/dct_rle_encoder.sv
// dct_rle_encoder: turns one zigzag-ordered coefficient block into (run, level) tokens plus an EOB token
module dct_rle_encoder
  import dct_rle_encoder_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NCOEF*COEF_W-1:0] in_coefs,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [RUN_W-1:0]        out_run,
  output logic [COEF_W-1:0]       out_level,
  output logic                    out_eob,
  output logic [CNT_W-1:0]        blk_count
);
  state_t                  r_state;
  logic [NCOEF*COEF_W-1:0] r_buf;
  logic [IDX_W-1:0]        r_idx;
  logic [RUN_W-1:0]        r_run;
  logic [COEF_W-1:0]       w_coef;
  logic                    w_stall;
  logic                    w_take;

  assign w_stall  = out_valid && !out_ready;
  assign w_take   = out_valid && out_ready;
  assign in_ready = r_state == ST_IDLE;

  dct_coef_mux u_mux (.i_buf(r_buf), .i_idx(r_idx), .o_coef(w_coef));

  // A stalled token freezes the whole datapath so out_* stays stable until taken
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state   <= ST_IDLE;
      r_buf     <= '0;
      r_idx     <= '0;
      r_run     <= '0;
      out_valid <= 1'b0;
      out_run   <= '0;
      out_level <= '0;
      out_eob   <= 1'b0;
      blk_count <= '0;
    end else if (!w_stall)
      case (r_state)
        ST_IDLE:
          if (in_valid) begin
            r_buf   <= in_coefs;
            r_idx   <= '0;
            r_run   <= '0;
            r_state <= ST_SCAN;
          end
        ST_SCAN: begin
          if (w_coef != '0) begin
            out_run   <= r_run;
            out_level <= w_coef;
            out_eob   <= 1'b0;
            out_valid <= 1'b1;
            r_run     <= '0;
          end else begin
            r_run <= r_run + 1'b1;
            if (w_take) out_valid <= 1'b0;
          end
          r_idx <= r_idx + 1'b1;
          if (r_idx == IDX_W'(NCOEF - 1)) r_state <= ST_EOB;
        end
        ST_EOB:
          if (!out_eob) begin
            out_run   <= '0;
            out_level <= '0;
            out_eob   <= 1'b1;
            out_valid <= 1'b1;
          end else begin
            out_valid <= 1'b0;
            out_eob   <= 1'b0;
            blk_count <= blk_count + 1'b1;
            r_state   <= ST_IDLE;
          end
        default: r_state <= ST_IDLE;
      endcase
endmodule
